reg_fifo_rd: RTL and testbench

Register-based buffer that drains enable-qualified register writes out to a valid/ready consumer. Upstream logic writes with a single `i_en` strobe and `i_data` word, the same write style as the base register cells. Downstream logic reads through a first-word-fall-through valid/ready port. The block sits in `src/base/reg` and is the read-side counterpart of the enable register: it decouples a producer that cannot stall from a consumer that can.

---
 rtl/reg_fifo_rd.sv | 84 ++++++++
 tb/tb_reg_fifo_rd.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_fifo_rd.sv
// Register-based FWFT buffer: enable-strobed writes in, valid/ready reads out.
// Writes arriving while full are dropped and latch a sticky overflow flag.
module reg_fifo_rd #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic                         o_full,
    output logic                         o_ovf,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop;

    // Flags come from the count register only, so they never follow inputs combinationally.
    assign o_valid = (count_q != '0);
    assign o_full  = (count_q == CntW'(DEPTH));
    assign o_count = count_q;
    assign o_ovf   = ovf_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign push = i_en && !o_full;
    assign pop  = o_valid && i_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (i_en && o_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_reg_fifo_rd.sv
// Directed self-checking bench for reg_fifo_rd (DATA_WIDTH=32, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reg_fifo_rd;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic [31:0] i_data;
    logic        o_full;
    logic        o_ovf;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_fifo_rd #(
        .DATA_WIDTH(32),
        .DEPTH     (4)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (i_en),
        .i_data (i_data),
        .o_full (o_full),
        .o_ovf  (o_ovf),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_count(o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_en    = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        i_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_en   = 1'b1;
            i_data = first + 32'(k);
            step();
        end
        i_en = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_ready = 1'b0;
        i_data  = 32'hFFFF0000;
        step();
        step();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid);
        end
        n_checks++;
        if (o_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", o_count);
        end
        n_checks++;
        if (o_ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b want 0", o_ovf);
        end
        n_checks++;
        if (o_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", o_data);
        end
        i_en    = 1'b0;
        i_rst_n = 1'b1;
        step();
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: valid %b count %0d want 0 0", o_valid, o_count);
        end
    endtask

    task automatic test_fill_drain();
        push_words(32'h1, 4);
        n_checks++;
        if (o_full !== 1'b1 || o_count !== 3'd4 || o_data !== 32'h1) begin
            n_fail++;
            $display("FAIL fill: full %b count %0d data %h want 1 4 00000001",
                     o_full, o_count, o_data);
        end
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 32'(k)) begin
                n_fail++;
                $display("FAIL drain_%0d: valid %b data %h want 1 %h", k, o_valid, o_data, 32'(k));
            end
            step();
        end
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            n_fail++; $display("FAIL drain_empty: valid %b count %0d want 0 0", o_valid, o_count);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        push_words(32'h1, 4);
        i_en   = 1'b1;
        i_data = 32'hDEAD;
        step();
        i_en = 1'b0;
        n_checks++;
        if (o_ovf !== 1'b1 || o_count !== 3'd4) begin
            n_fail++; $display("FAIL ovf_set: ovf %b count %0d want 1 4", o_ovf, o_count);
        end
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 32'(k)) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: valid %b data %h want 1 %h", k, o_valid, o_data, 32'(k));
            end
            step();
        end
        i_ready = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: valid %b ovf %b want 0 1", o_valid, o_ovf);
        end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        push_words(32'h10, 2);
        // Pushes 0x12..0x1B while popping; heads run 0x10..0x19 across two pointer wraps.
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_en   = 1'b1;
            i_data = 32'h12 + 32'(k);
            n_checks++;
            if (o_data !== 32'h10 + 32'(k)) begin
                n_fail++; $display("FAIL pp_data_%0d: got %h want %h", k, o_data, 32'h10 + 32'(k));
            end
            step();
            n_checks++;
            if (o_count !== 3'd2) begin
                n_fail++; $display("FAIL pp_count_%0d: got %0d want 2", k, o_count);
            end
        end
        i_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 32'h1A + 32'(k)) begin
                n_fail++;
                $display("FAIL pp_tail_%0d: valid %b data %h want 1 %h",
                         k, o_valid, o_data, 32'h1A + 32'(k));
            end
            step();
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL pp_empty: valid %b want 0", o_valid);
        end

        do_reset();
        push_words(32'h1, 4);
        i_en    = 1'b1;
        i_data  = 32'hBEEF;
        i_ready = 1'b1;
        step();
        i_en = 1'b0;
        n_checks++;
        if (o_count !== 3'd3 || o_ovf !== 1'b1 || o_full !== 1'b0 || o_data !== 32'h2) begin
            n_fail++;
            $display("FAIL full_pp: count %0d ovf %b full %b data %h want 3 1 0 00000002",
                     o_count, o_ovf, o_full, o_data);
        end
        for (int k = 2; k <= 4; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 32'(k)) begin
                n_fail++;
                $display("FAIL full_pp_drain_%0d: valid %b data %h want 1 %h",
                         k, o_valid, o_data, 32'(k));
            end
            step();
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_pp_beef_absent: valid %b want 0", o_valid);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        push_words(32'hFFFFFFFF, 1);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 32'hFFFFFFFF) begin
                n_fail++;
                $display("FAIL hold_%0d: valid %b data %h want 1 ffffffff", k, o_valid, o_data);
            end
            step();
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0) begin
            n_fail++; $display("FAIL hold_pop: valid %b count %0d want 0 0", o_valid, o_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_words(32'h7, 4);
        // Overflow while popping leaves count 3 with ovf set.
        i_en    = 1'b1;
        i_ready = 1'b1;
        i_data  = 32'h99;
        step();
        i_en    = 1'b0;
        i_ready = 1'b0;
        n_checks++;
        if (o_count !== 3'd3 || o_ovf !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: count %0d ovf %b want 3 1", o_count, o_ovf);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 3'd0 || o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: valid %b count %0d ovf %b want 0 0 0",
                     o_valid, o_count, o_ovf);
        end
        step();
        i_rst_n = 1'b1;
        push_words(32'hA5A5A5A5, 1);
        n_checks++;
        if (o_count !== 3'd1 || o_valid !== 1'b1 || o_data !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL mid_after: count %0d valid %b data %h want 1 1 a5a5a5a5",
                     o_count, o_valid, o_data);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_push_pop();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
